rv_wb_sched: RTL and testbench

Write-back scheduler and register scoreboard for the rv32 core. It sits directly upstream of the register file write port (`awd`/`we`/`wd`). It merges single-cycle pipeline results with results from long-latency units (mul/div, load miss) into that one port. It tracks which registers have a long-latency write outstanding and stalls issue on RAW/WAW hazards against them.

---
 rtl/rv_wb_sched.sv | 178 +++++++++++++++++
 tb/tb_rv_wb_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_sched.sv
// rv_wb_sched: write-back scheduler and long-latency register scoreboard.
// Merges single-cycle pipeline results and queued long-unit results onto the
// single register-file write port (pipeline has priority). It also stalls issue
// on hazards against registers that still have a long write outstanding.
// Optional feature macro: RV_WBS_PERF_EN adds the perf_stall_cnt/perf_defer_cnt
// counters. Without the macro, those ports and counters are absent.
module rv_wb_sched #(
  parameter int Nregs = 16,
  parameter int Nlong = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic        iss_long,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  output logic        iss_stall,
  input  logic        pwb_valid,
  input  logic [4:0]  pwb_rd,
  input  logic [31:0] pwb_data,
  input  logic        lwb_valid,
  output logic        lwb_ready,
  input  logic [4:0]  lwb_rd,
  input  logic [31:0] lwb_data,
  output logic [4:0]  awd,
  output logic        we,
  output logic [31:0] wd
`ifdef RV_WBS_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_defer_cnt
`endif
);

  localparam int PW = (Nlong > 1) ? $clog2(Nlong) : 1;
  localparam int CW = $clog2(Nlong + 1);

  // A destination is writable only if it is a tracked, non-zero register.
  function automatic logic rd_ok(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) < Nregs);
  endfunction

  // Index 0 and out-of-range indices never read as pending.
  function automatic logic is_pend(input logic [Nregs-1:0] p, input logic [4:0] r);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < Nregs; i++) begin
      if (int'(r) == i && p[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (int'(p) == Nlong - 1) return '0;
    return p + 1'b1;
  endfunction

  logic [Nregs-1:0] pending_q, pending_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [4:0]       q_rd   [Nlong];
  logic [31:0]      q_data [Nlong];
  logic             we_q, we_d, wlong_q, wlong_d;
  logic [4:0]       awd_q, awd_d;
  logic [31:0]      wd_q, wd_d;
  logic             push, pop, iss_fire;
  int               inflight;

  // Hazard detection against the scoreboard and the in-flight limit.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < Nregs; i++) inflight += int'(pending_q[i]);
    iss_stall = iss_valid & (is_pend(pending_q, iss_rs1) | is_pend(pending_q, iss_rs2) |
                             is_pend(pending_q, iss_rd) | (iss_long & (inflight == Nlong)));
    iss_fire  = iss_valid & ~iss_stall & iss_long & rd_ok(iss_rd);
  end

  // Queue handshake: no full-bypass, pop only when the pipeline is idle.
  always_comb begin
    lwb_ready = int'(count_q) < Nlong;
    push      = lwb_valid & lwb_ready;
    pop       = ~pwb_valid & (count_q != '0);
    wr_ptr_d  = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Write-port selection: pipeline result first, otherwise the queue head.
  always_comb begin
    we_d    = 1'b0;
    wlong_d = 1'b0;
    awd_d   = awd_q;
    wd_d    = wd_q;
    if (pwb_valid) begin
      we_d  = rd_ok(pwb_rd);
      awd_d = pwb_rd;
      wd_d  = pwb_data;
    end else if (pop) begin
      we_d    = rd_ok(q_rd[rd_ptr_q]);
      wlong_d = 1'b1;
      awd_d   = q_rd[rd_ptr_q];
      wd_d    = q_data[rd_ptr_q];
    end
  end

  // Scoreboard update: release on a registered long write, set on long issue.
  always_comb begin
    pending_d = pending_q;
    if (we_q && wlong_q) begin
      for (int i = 0; i < Nregs; i++) begin
        if (int'(awd_q) == i) pending_d[i] = 1'b0;
      end
    end
    if (iss_fire) begin
      for (int i = 1; i < Nregs; i++) begin
        if (int'(iss_rd) == i) pending_d[i] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  // Control state and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      wlong_q   <= 1'b0;
      awd_q     <= '0;
      wd_q      <= '0;
    end else begin
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      wlong_q   <= wlong_d;
      awd_q     <= awd_d;
      wd_q      <= wd_d;
    end
  end

  // Queue storage; contents are only meaningful under count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr_q]   <= lwb_rd;
      q_data[wr_ptr_q] <= lwb_data;
    end
  end

  assign we  = we_q;
  assign awd = awd_q;
  assign wd  = wd_q;

`ifdef RV_WBS_PERF_EN
  logic [31:0] stall_cnt_q, defer_cnt_q;

  // Performance counters: stalled issue cycles and queue deferrals.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      defer_cnt_q <= '0;
    end else begin
      if (iss_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pwb_valid && count_q != '0) defer_cnt_q <= defer_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_defer_cnt = defer_cnt_q;
`endif

endmodule

// File: tb/tb_rv_wb_sched.sv
// Testbench for rv_wb_sched: a per-cycle vector table followed by hand-written
// sequences for reset during operation and, when RV_WBS_PERF_EN is defined,
// for the performance counters.
module tb_rv_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        pwb_valid;
  logic [4:0]  pwb_rd;
  logic [31:0] pwb_data;
  logic        lwb_valid, lwb_ready;
  logic [4:0]  lwb_rd;
  logic [31:0] lwb_data;
  logic [4:0]  awd;
  logic        we;
  logic [31:0] wd;
`ifdef RV_WBS_PERF_EN
  logic [31:0] perf_stall_cnt, perf_defer_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  rv_wb_sched #(.Nregs(16), .Nlong(2)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
    .pwb_valid(pwb_valid), .pwb_rd(pwb_rd), .pwb_data(pwb_data),
    .lwb_valid(lwb_valid), .lwb_ready(lwb_ready), .lwb_rd(lwb_rd), .lwb_data(lwb_data),
    .awd(awd), .we(we), .wd(wd)
`ifdef RV_WBS_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_defer_cnt(perf_defer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, il;
    logic [4:0]  ird, rs1, rs2;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_stall, e_ready, e_we;
    logic [4:0]  e_awd;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic iv, input logic il, input logic [4:0] ird,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic es, input logic er, input logic ewe,
                              input logic [4:0] eawd, input logic [31:0] ewd);
    vec_t v;
    v.iv = iv; v.il = il; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.pv = pv; v.prd = prd; v.pd = pd;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_stall = es; v.e_ready = er; v.e_we = ewe; v.e_awd = eawd; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    pwb_valid = 0; pwb_rd = 0; pwb_data = 0;
    lwb_valid = 0; lwb_rd = 0; lwb_data = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle-by-cycle vectors: outputs checked are the combinational stall/ready
    // for this cycle's inputs and the write port registered at the previous edge.
    //        iv il ird rs1 rs2  pv prd pd            lv lrd ld            st rdy we awd wd
    vt.push_back(mk(0,0,0,0,0,  1,5,32'hDEADBEEF,   0,0,0,              0,1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,  1,0,32'h11111111,   0,0,0,              0,1,1,5,32'hDEADBEEF));
    vt.push_back(mk(0,0,0,0,0,  0,0,0,              0,0,0,              0,1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,  0,0,0,              0,0,0,              0,1,0,0,0));
    vt.push_back(mk(1,1,7,0,0,  0,0,0,              0,0,0,              0,1,0,0,0));
    vt.push_back(mk(1,0,8,7,0,  0,0,0,              0,0,0,              1,1,0,0,0));
    vt.push_back(mk(1,0,8,7,0,  0,0,0,              1,7,32'h12345678,   1,1,0,0,0));
    vt.push_back(mk(1,0,8,7,0,  0,0,0,              0,0,0,              1,1,0,0,0));
    vt.push_back(mk(1,0,8,7,0,  0,0,0,              0,0,0,              1,1,1,7,32'h12345678));
    vt.push_back(mk(1,0,8,7,0,  0,0,0,              0,0,0,              0,1,0,0,0));
    vt.push_back(mk(1,1,3,0,0,  1,10,32'hA0,        1,3,32'h33333333,   0,1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,  1,11,32'hA1,        0,0,0,              0,1,1,10,32'hA0));
    vt.push_back(mk(0,0,0,0,0,  1,12,32'hA2,        0,0,0,              0,1,1,11,32'hA1));
    vt.push_back(mk(0,0,0,0,0,  1,13,32'hA3,        0,0,0,              0,1,1,12,32'hA2));
    vt.push_back(mk(0,0,0,0,0,  0,0,0,              0,0,0,              0,1,1,13,32'hA3));
    vt.push_back(mk(1,0,9,0,3,  0,0,0,              0,0,0,              1,1,1,3,32'h33333333));
    vt.push_back(mk(1,0,9,0,3,  0,0,0,              0,0,0,              0,1,0,0,0));
    vt.push_back(mk(1,1,1,0,0,  0,0,0,              0,0,0,              0,1,0,0,0));
    vt.push_back(mk(1,1,2,0,0,  0,0,0,              0,0,0,              0,1,0,0,0));
    vt.push_back(mk(1,1,4,0,0,  1,14,32'hB0,        1,1,32'h1111,       1,1,0,0,0));
    vt.push_back(mk(1,1,4,0,0,  1,15,32'hB1,        1,2,32'h2222,       1,1,1,14,32'hB0));
    vt.push_back(mk(1,1,4,0,0,  1,14,32'hB2,        1,6,32'h6666,       1,0,1,15,32'hB1));
    vt.push_back(mk(1,1,4,0,0,  0,0,0,              1,6,32'h6666,       1,0,1,14,32'hB2));
    vt.push_back(mk(1,1,4,0,0,  0,0,0,              1,6,32'h6666,       1,1,1,1,32'h1111));
    vt.push_back(mk(1,1,4,0,0,  0,0,0,              0,0,0,              0,1,1,2,32'h2222));
    vt.push_back(mk(0,0,0,0,0,  0,0,0,              0,0,0,              0,1,1,6,32'h6666));
    vt.push_back(mk(0,0,0,0,0,  0,0,0,              1,20,32'h20,        0,1,0,0,0));
    vt.push_back(mk(1,0,9,4,0,  0,0,0,              0,0,0,              1,1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,  1,16,32'h16,        0,0,0,              0,1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,  0,0,0,              0,0,0,              0,1,0,0,0));

    // Reset held for two edges with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iss_valid = 1'($urandom); iss_long = 1'($urandom); iss_rd = 5'($urandom);
      iss_rs1 = 5'($urandom); iss_rs2 = 5'($urandom);
      pwb_valid = 1'($urandom); pwb_rd = 5'($urandom); pwb_data = $urandom;
      lwb_valid = 1'($urandom); lwb_rd = 5'($urandom); lwb_data = $urandom;
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    idle_inputs();
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd3; iss_rs1 = 5'd7; iss_rs2 = 5'd9;
    #1;
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_awd", 32'(awd), 32'd0);
    chk("reset_wd", wd, 32'd0);
    chk("reset_lwb_ready", 32'(lwb_ready), 32'd1);
    chk("reset_iss_stall", 32'(iss_stall), 32'd0);
    idle_inputs();
    next_cycle();

    foreach (vt[k]) begin
      iss_valid = vt[k].iv; iss_long = vt[k].il; iss_rd = vt[k].ird;
      iss_rs1 = vt[k].rs1; iss_rs2 = vt[k].rs2;
      pwb_valid = vt[k].pv; pwb_rd = vt[k].prd; pwb_data = vt[k].pd;
      lwb_valid = vt[k].lv; lwb_rd = vt[k].lrd; lwb_data = vt[k].ld;
      #1;
      chk($sformatf("v%0d_stall", k), 32'(iss_stall), 32'(vt[k].e_stall));
      chk($sformatf("v%0d_ready", k), 32'(lwb_ready), 32'(vt[k].e_ready));
      chk($sformatf("v%0d_we", k), 32'(we), 32'(vt[k].e_we));
      if (vt[k].e_we) begin
        chk($sformatf("v%0d_awd", k), 32'(awd), 32'(vt[k].e_awd));
        chk($sformatf("v%0d_wd", k), wd, vt[k].e_wd);
      end
      next_cycle();
    end

    // Reset mid-operation: register 4 is still pending from the table.
    idle_inputs();
    iss_valid = 1; iss_rs1 = 5'd4; iss_rd = 5'd11;
    lwb_valid = 1; lwb_rd = 5'd9; lwb_data = 32'h99;
    pwb_valid = 1; pwb_rd = 5'd5; pwb_data = 32'h55;
    #1;
    chk("midrst_pre_stall", 32'(iss_stall), 32'd1);
    next_cycle();
    idle_inputs();
    rst = 1; pwb_valid = 1; pwb_rd = 5'd5; pwb_data = 32'h56;
    #1;
    chk("midrst_pre_we", 32'(we), 32'd1);
    chk("midrst_pre_awd", 32'(awd), 32'd5);
    next_cycle();
    rst = 0;
    idle_inputs();
    iss_valid = 1; iss_rs1 = 5'd4; iss_rd = 5'd11;
    #1;
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_stall", 32'(iss_stall), 32'd0);
    chk("midrst_ready", 32'(lwb_ready), 32'd1);
    next_cycle();
    idle_inputs();
    #1;
    chk("midrst_queue_discarded_we", 32'(we), 32'd0);
    next_cycle();

`ifdef RV_WBS_PERF_EN
    // Ten stalled cycles against a pending register, then reset.
    rst = 1;
    next_cycle();
    rst = 0;
    iss_valid = 1; iss_long = 1; iss_rd = 5'd5;
    next_cycle();
    iss_long = 0; iss_rd = 5'd12; iss_rs1 = 5'd5;
    for (int i = 0; i < 10; i++) next_cycle();
    idle_inputs();
    next_cycle();
    chk("perf_stall_cnt", perf_stall_cnt, 32'd10);
    chk("perf_defer_cnt", perf_defer_cnt, 32'd0);
    rst = 1;
    next_cycle();
    rst = 0;
    chk("perf_stall_cnt_reset", perf_stall_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
